// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker program loader.
// Optional checksum support is selected by TINKER_LOADER_CHECKSUM_EN in the loader top.
package tinker_pkg;

  localparam logic [63:0] RESET_PC   = 64'h2000;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    COLLECT,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  // Number of data bytes held in a word once lane idx has been filled.
  function automatic logic [IDX_W:0] lanes_filled(input logic [IDX_W-1:0] idx);
    return (IDX_W + 1)'(idx) + (IDX_W + 1)'(1);
  endfunction

endpackage

// File: rtl/tinker_byte_packer.sv
// Little-endian byte-to-word packer: lane index counter and zero-padded packing buffer.
// Shared by both builds of the loader (TINKER_LOADER_CHECKSUM_EN has no effect here).
module tinker_byte_packer
  import tinker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [7:0]       data,
  output logic [IDX_W-1:0] idx,
  output logic [63:0]      buffer
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      buf_q, buf_d;

  // Clearing to zero is what provides the padding of a short final word.
  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (clear) begin
      idx_d = '0;
      buf_d = '0;
    end else if (load) begin
      buf_d[{idx_q, 3'b000} +: 8] = data;
      idx_d                       = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  assign idx    = idx_q;
  assign buffer = buf_q;

endmodule

// File: rtl/tinker_program_loader.sv
// Streams a byte image into unified memory from BASE_ADDR and holds the core until it is loaded.
// Define TINKER_LOADER_CHECKSUM_EN to treat the s_last byte as an XOR checksum of the data.
module tinker_program_loader
  import tinker_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = RESET_PC,
  parameter int unsigned MEM_BYTES = 524288,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             mem_wr_en,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wr_data,
  output logic             core_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] bytes_loaded
);

  loader_state_t    state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic             last_q, last_d;
  logic             s_ready_q;
  logic             mem_wr_en_q;
  logic [63:0]      mem_addr_q;
  logic [CNT_W-1:0] bytes_q;

  logic             accept;
  logic             load;
  logic             clear;
  logic             go_write;
  logic             wr_start;
  logic             overflow;
  logic [IDX_W:0]   word_count;
  logic [IDX_W-1:0] idx;
  logic [63:0]      buffer;

`ifdef TINKER_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic [7:0] chk_q, chk_d;
`endif

  assign accept   = s_valid && s_ready_q;
  assign overflow = (addr_q + 64'(WORD_BYTES)) > 64'(MEM_BYTES);
  assign clear    = (state_q != COLLECT);
  assign wr_start = go_write && !overflow;

  tinker_byte_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .clear  (clear),
    .data   (s_data),
    .idx    (idx),
    .buffer (buffer)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    load       = 1'b0;
    go_write   = 1'b0;
    word_count = lanes_filled(idx);
`ifdef TINKER_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
    chk_d      = chk_q;
`endif
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
`ifdef TINKER_LOADER_CHECKSUM_EN
          if (s_last) begin
            // Checksum byte is not stored; flush a pending partial word first.
            last_d     = 1'b1;
            chk_d      = s_data;
            word_count = (IDX_W + 1)'(idx);
            if (idx != '0) begin
              go_write = 1'b1;
            end else begin
              state_d = (xor_q == s_data) ? DONE : ERROR;
            end
          end else begin
            load  = 1'b1;
            xor_d = xor_q ^ s_data;
            if (idx == '1) begin
              go_write = 1'b1;
            end
          end
`else
          load   = 1'b1;
          last_d = s_last;
          if ((idx == '1) || s_last) begin
            go_write = 1'b1;
          end
`endif
          if (go_write) begin
            state_d = overflow ? ERROR : WRITE;
          end
        end
      end
      WRITE: begin
        addr_d = addr_q + 64'(WORD_BYTES);
        if (last_q) begin
`ifdef TINKER_LOADER_CHECKSUM_EN
          state_d = (xor_q == chk_q) ? DONE : ERROR;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= COLLECT;
      addr_q      <= BASE_ADDR;
      last_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      bytes_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      s_ready_q   <= (state_d == COLLECT);
      mem_wr_en_q <= wr_start;
      if (wr_start) begin
        mem_addr_q <= addr_q;
        bytes_q    <= bytes_q + CNT_W'(word_count);
      end
    end
  end

`ifdef TINKER_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      xor_q <= '0;
      chk_q <= '0;
    end else begin
      xor_q <= xor_d;
      chk_q <= chk_d;
    end
  end
`endif

  assign s_ready      = s_ready_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_addr     = mem_addr_q;
  // The packing buffer is a register holding the word for exactly the WRITE cycle.
  assign mem_wr_data  = buffer;
  assign core_hold    = (state_q != DONE);
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERROR);
  assign bytes_loaded = bytes_q;

endmodule

// File: tb/tb_tinker_program_loader.sv
// Scoreboard bench for tinker_program_loader; expected writes are queued as bytes are driven.
// Build with TINKER_LOADER_CHECKSUM_EN defined to exercise the checksum variant instead.
module tb_tinker_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v0, v1;
  logic [7:0]  s_data;
  logic        s_last;
  logic        r0, r1, we0, we1;
  logic [63:0] a0, a1, d0, d1;
  logic        h0, h1, dn0, dn1, e0, e1;
  logic [31:0] b0, b1;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [127:0] exp0, exp1;

  always @(posedge clk) cycle <= cycle + 1;

  tinker_program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (v0),
    .s_ready      (r0),
    .s_data       (s_data),
    .s_last       (s_last),
    .mem_wr_en    (we0),
    .mem_addr     (a0),
    .mem_wr_data  (d0),
    .core_hold    (h0),
    .done         (dn0),
    .err          (e0),
    .bytes_loaded (b0)
  );

  tinker_program_loader #(
    .BASE_ADDR (64'h7FFF8),
    .MEM_BYTES (524288),
    .CNT_W     (32)
  ) dut_ovf (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (v1),
    .s_ready      (r1),
    .s_data       (s_data),
    .s_last       (s_last),
    .mem_wr_en    (we1),
    .mem_addr     (a1),
    .mem_wr_data  (d1),
    .core_hold    (h1),
    .done         (dn1),
    .err          (e1),
    .bytes_loaded (b1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("unexpected_wr0", 64'd1, 64'd0);
      end else begin
        exp0 = q0.pop_front();
        check("wr0_addr", a0, exp0[127:64]);
        check("wr0_data", d0, exp0[63:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (we1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("unexpected_wr1", 64'd1, 64'd0);
      end else begin
        exp1 = q1.pop_front();
        check("wr1_addr", a1, exp1[127:64]);
        check("wr1_data", d1, exp1[63:0]);
      end
    end
  end

  task automatic idle();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Leaves s_valid high so consecutive calls stream back to back.
  task automatic send(input int s, input logic [7:0] d, input logic l, input int limit,
                      output bit acc, output int t);
    s_data = d;
    s_last = l;
    if (s == 1) v1 = 1'b1;
    else        v0 = 1'b1;
    acc = 1'b0;
    t   = 0;
    for (int i = 0; i < limit && !acc; i++) begin
      @(negedge clk);
      if (((s == 1) ? r1 : r0) === 1'b1) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
        t   = cycle;
      end
    end
  endtask

  task automatic put(input int s, input logic [7:0] d, input logic l);
    bit acc;
    int t;
    send(s, d, l, 30, acc, t);
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_end(input int s);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (s == 1) fin = (dn1 === 1'b1) || (e1 === 1'b1);
      else        fin = (dn0 === 1'b1) || (e0 === 1'b1);
    end
    if (!fin) check("end_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    idle();
    s_last = 1'b0;
    reset  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(r0), 64'd0);
    check("rst_wr_en", 64'(we0), 64'd0);
    check("rst_addr", a0, 64'h2000);
    check("rst_data", d0, 64'd0);
    check("rst_hold", 64'(h0), 64'd1);
    check("rst_done", 64'(dn0), 64'd0);
    check("rst_err", 64'(e0), 64'd0);
    check("rst_bytes", 64'(b0), 64'd0);
    reset = 1'b1;
  endtask

  task automatic check_end0(input string tag, input logic exp_done, input logic [31:0] exp_bytes);
    check({tag, "_done"}, 64'(dn0), 64'(exp_done));
    check({tag, "_err"}, 64'(e0), 64'(!exp_done));
    check({tag, "_hold"}, 64'(h0), 64'(!exp_done));
    check({tag, "_bytes"}, 64'(b0), 64'(exp_bytes));
    check({tag, "_sb_empty"}, 64'(q0.size()), 64'd0);
  endtask

  logic [63:0] word;
  int          tacc[16];
  bit          acc;
  int          tt;

  initial begin
    reset  = 1'b0;
    v0     = 1'b0;
    v1     = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;

`ifndef TINKER_LOADER_CHECKSUM_EN
    // Single full word ending on lane 7.
    do_reset();
    q0.push_back({64'h2000, 64'h0807060504030201});
    for (int i = 1; i <= 8; i++) put(0, 8'(i), i == 8);
    idle();
    wait_end(0);
    check_end0("w8", 1'b1, 32'd8);
    send(0, 8'h55, 1'b1, 5, acc, tt);
    idle();
    check("done_ignore", 64'(acc), 64'd0);
    check("done_bytes_hold", 64'(b0), 64'd8);

    // Twelve bytes: one full word plus a zero-padded partial word.
    do_reset();
    q0.push_back({64'h2000, 64'h1716151413121110});
    q0.push_back({64'h2008, 64'h000000001B1A1918});
    for (int i = 0; i < 12; i++) put(0, 8'(8'h10 + i), i == 11);
    idle();
    wait_end(0);
    check_end0("w12", 1'b1, 32'd12);

    // Continuous valid for sixteen bytes; one bubble after the 8th byte.
    do_reset();
    word = '0;
    for (int i = 0; i < 16; i++) begin
      word[(i % 8) * 8 +: 8] = 8'(8'h30 + i);
      if (i % 8 == 7) begin
        q0.push_back({64'h2000 + 64'((i / 8) * 8), word});
        word = '0;
      end
    end
    for (int i = 0; i < 16; i++) begin
      send(0, 8'(8'h30 + i), i == 15, 30, acc, tt);
      if (!acc) check("stream_timeout", 64'd0, 64'd1);
      tacc[i] = tt;
    end
    idle();
    for (int i = 1; i < 16; i++) begin
      check($sformatf("gap_%0d", i), 64'(tacc[i] - tacc[i-1]), (i == 8) ? 64'd2 : 64'd1);
    end
    wait_end(0);
    check_end0("w16", 1'b1, 32'd16);

    // Reset mid-load discards partially collected bytes.
    do_reset();
    for (int i = 0; i < 5; i++) put(0, 8'(8'h50 + i), 1'b0);
    do_reset();
    q0.push_back({64'h2000, 64'h00000000AAAAAAAA});
    for (int i = 0; i < 4; i++) put(0, 8'hAA, i == 3);
    idle();
    wait_end(0);
    check_end0("rst_mid", 1'b1, 32'd4);

    // Second word would pass the end of memory.
    do_reset();
    q1.push_back({64'h7FFF8, 64'h0807060504030201});
    for (int i = 1; i <= 9; i++) put(1, 8'(i), i == 9);
    idle();
    wait_end(1);
    repeat (4) @(negedge clk);
    check("ovf_err", 64'(e1), 64'd1);
    check("ovf_hold", 64'(h1), 64'd1);
    check("ovf_done", 64'(dn1), 64'd0);
    check("ovf_bytes", 64'(b1), 64'd8);
    check("ovf_sb_empty", 64'(q1.size()), 64'd0);
`else
    // Matching checksum after a partial word.
    do_reset();
    q0.push_back({64'h2000, 64'h0000000000040201});
    put(0, 8'h01, 1'b0);
    put(0, 8'h02, 1'b0);
    put(0, 8'h04, 1'b0);
    put(0, 8'h07, 1'b1);
    idle();
    wait_end(0);
    check_end0("chk_ok", 1'b1, 32'd3);

    // Mismatching checksum still writes the data, then errors.
    do_reset();
    q0.push_back({64'h2000, 64'h0000000000040201});
    put(0, 8'h01, 1'b0);
    put(0, 8'h02, 1'b0);
    put(0, 8'h04, 1'b0);
    put(0, 8'h06, 1'b1);
    idle();
    wait_end(0);
    check_end0("chk_bad", 1'b0, 32'd3);

    // Empty image: checksum 0x00 with no write.
    do_reset();
    put(0, 8'h00, 1'b1);
    idle();
    wait_end(0);
    check_end0("chk_empty", 1'b1, 32'd0);

    // Full word then checksum with nothing pending.
    do_reset();
    q0.push_back({64'h2000, 64'h0807060504030201});
    for (int i = 1; i <= 8; i++) put(0, 8'(i), 1'b0);
    put(0, 8'h08, 1'b1);
    idle();
    wait_end(0);
    check_end0("chk_full", 1'b1, 32'd8);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tinker_program_loader.md
Name: tinker_program_loader

Overview:
- Writer-side counterpart to the core's instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 64-bit words.
- Writes those words into unified memory starting at the core reset PC (0x2000).
- Holds the core in reset until the image is fully written, then releases it and reports done or error.

Parameters:
- BASE_ADDR, 64'h2000, first memory address written; equals the core reset PC.
- MEM_BYTES, 524288, memory size in bytes; any write reaching past this size is an overflow.
- CNT_W, 32, width of the bytes_loaded counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- s_valid  in  1  input byte valid.
- s_ready  out  1  loader can accept a byte.
- s_data  in  8  input byte.
- s_last  in  1  marks the final byte of the image; qualified by s_valid.
- mem_wr_en  out  1  one-cycle write strobe to memory.
- mem_addr  out  64  write address; always 8-byte aligned relative to BASE_ADDR.
- mem_wr_data  out  64  write data; byte k sits in bits [8k+7:8k].
- core_hold  out  1  active-high reset to the core; 1 until the load completes.
- done  out  1  load completed successfully (sticky).
- err  out  1  overflow or checksum failure (sticky).
- bytes_loaded  out  CNT_W  count of data bytes written to memory.

Behaviour:
- Reset values (reset=0 at posedge): state=COLLECT, s_ready=0, mem_wr_en=0, mem_addr=BASE_ADDR, mem_wr_data=0, core_hold=1, done=0, err=0, bytes_loaded=0, byte index=0, packing buffer=0.
- A byte is accepted when s_valid && s_ready at a posedge.
- States:
  - COLLECT: s_ready=1. An accepted byte goes into buffer lane idx, then idx increments. If idx was 7 or s_last=1, go to WRITE; otherwise stay.
  - WRITE: s_ready=0. For exactly one cycle mem_wr_en=1, mem_addr=current address, mem_wr_data=buffer. Unfilled lanes are 0 (zero padding). bytes_loaded increases by the number of data bytes in the word. Next cycle: address += 8, buffer=0, idx=0. Go to DONE if the word held the last byte, otherwise back to COLLECT.
  - DONE: s_ready=0, done=1, core_hold=0. Terminal until reset.
  - ERROR: s_ready=0, err=1, core_hold=1, no further writes. Terminal until reset.
- Overflow: on entering WRITE, if address+8 > MEM_BYTES, suppress the write (mem_wr_en stays 0) and go to ERROR.
- s_last arriving with idx=7 produces a single write, then DONE.
- Back-to-back bytes: throughput is 8 bytes per 9 cycles; the WRITE cycle inserts one bubble.
- Reset mid-load: everything returns to reset values; partially collected bytes are discarded; already-written memory is left untouched.
- s_valid during DONE or ERROR is ignored (s_ready=0).
- s_data and s_last are don't-care when s_valid=0.
- mem_wr_en, mem_addr and mem_wr_data are registered outputs.
- mem_addr holds its last value outside the WRITE cycle.

Optional Feature:
- Macro: TINKER_LOADER_CHECKSUM_EN.
- Defined:
  - The byte flagged s_last is a checksum and is not stored.
  - A running XOR covers all data bytes.
  - On the last byte: if a partial word is pending, go to WRITE. After that write (or immediately if none is pending), compare the checksum. Match → DONE; mismatch → ERROR.
  - s_last on the very first byte means an empty image: the checksum must be 0x00 and no write occurs.
- Undefined: the s_last byte is an ordinary data byte and no checksum logic exists.

Decomposition:
- Shared package tinker_pkg holds:
  - typedef loader_state_t {COLLECT, WRITE, DONE, ERROR}.
  - localparam RESET_PC = 64'h2000, used as the BASE_ADDR default.
  - localparam WORD_BYTES = 8.
- One natural sub-module, tinker_byte_packer: lane index counter, 64-bit packing buffer and zero padding.
- The FSM, address counter and checksum stay in the top module.

Test Plan:
- Stream 8 bytes 0x01..0x08 with s_last on byte 8 → one write, mem_addr=0x2000, mem_wr_data=0x0807060504030201; then done=1, core_hold=0, bytes_loaded=8.
- Stream 12 bytes 0x10..0x1B (s_last on 0x1B) → first write at 0x2000 = 0x1716151413121110; second write at 0x2008 = 0x000000001B1A1918; bytes_loaded=12.
- Hold s_valid=1 continuously for 16 bytes → s_ready drops exactly one cycle after each 8th byte; no byte lost or duplicated.
- Pulse reset=0 after 5 bytes, then stream 4 bytes 0xAA (last on 4th) → single write at 0x2000 = 0x00000000AAAAAAAA.
- BASE_ADDR=MEM_BYTES-8, stream 9 bytes → first write succeeds; second write suppressed; err=1, core_hold=1, done=0.
- With TINKER_LOADER_CHECKSUM_EN: data 0x01,0x02,0x04 then checksum 0x07 (last) → write 0x0000000000040201, done=1. Same data with checksum 0x06 → same write, then err=1, core_hold=1.
